// File: rtl/cmos_pkg.sv
// Shared types and constants for the CMOS frame packer.
// Holds the FSM state encoding and the FIFO entry layout {sof, eol, data}.
package cmos_pkg;
   localparam int WORD_W = 32;
   localparam int PIX_W  = 16;

   typedef enum logic [1:0] {
      WAIT_VS = 2'd0,
      VS_HIGH = 2'd1,
      ACTIVE  = 2'd2,
      DROP    = 2'd3
   } state_e;

   typedef struct packed {
      logic              sof;
      logic              eol;
      logic [WORD_W-1:0] data;
   } fifo_ent_t;
endpackage

// File: rtl/pix_fifo.sv
// Synchronous show-ahead FIFO: head entry visible while non-empty, valid one cycle after a push.
// Backpressure: a push is accepted when not full, or when full and a pop happens in the same cycle.
module pix_fifo
   import cmos_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      wr_en_i,
   input  fifo_ent_t wr_ent_i,
   output logic      full_o,
   input  logic      rd_en_i,
   output fifo_ent_t rd_ent_o,
   output logic      empty_o
);
   localparam int AW = $clog2(DEPTH);

   fifo_ent_t     mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [AW:0]   cnt_q;
   logic          wr_ok, rd_ok;

   assign empty_o  = (cnt_q == '0);
   assign full_o   = (cnt_q == (AW+1)'(DEPTH));
   assign rd_ok    = rd_en_i && !empty_o;
   assign wr_ok    = wr_en_i && (!full_o || rd_ok);
   assign rd_ent_o = empty_o ? '0 : mem_q[rp_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (wr_ok) wp_q <= wp_q + AW'(1);
         if (rd_ok) rp_q <= rp_q + AW'(1);
         if (wr_ok && !rd_ok)      cnt_q <= cnt_q + (AW+1)'(1);
         else if (!wr_ok && rd_ok) cnt_q <= cnt_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wp_q] <= wr_ent_i;
   end
endmodule

// File: rtl/cmos_frame_packer.sv
// Packs RGB565 pixel pairs into 32-bit words with sof/eol tags; a pair is pushed when the next pixel or href fall arrives.
// Valid/ready output through a show-ahead FIFO; overflow drops the rest of the frame. Optional CMOS_LINE_CHECK_EN adds line-length check.
module cmos_frame_packer
   import cmos_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int FCNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmos_frame_vsync,
   input  logic              cmos_frame_href,
   input  logic              cmos_frame_valid,
   input  logic [PIX_W-1:0]  cmos_frame_data,
   input  logic [12:0]       cmos_hpixel,
   output logic [WORD_W-1:0] wr_data,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic              wr_sof,
   output logic              wr_eol,
   output logic [FCNT_W-1:0] frame_cnt,
   output logic              overflow,
   output logic              line_err
);
   state_e              state_q, state_d;
   logic                vs_q, href_q;
   logic [PIX_W-1:0]    half_q, half_d;
   logic                half_vld_q, half_vld_d;
   logic [WORD_W-1:0]   hold_q, hold_d;
   logic                hold_vld_q, hold_vld_d;
   logic                sof_pend_q, sof_pend_d;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
   logic                ovf_q, ovf_d;
   logic                vs_rise, href_fall, pix, pop, push, full, empty;
   fifo_ent_t           push_ent, head_ent;

   assign vs_rise   = cmos_frame_vsync && !vs_q;
   assign href_fall = href_q && !cmos_frame_href;
   assign pix       = cmos_frame_href && cmos_frame_valid;
   assign wr_valid  = !empty;
   assign pop       = wr_valid && wr_ready;

   // A completed pair waits in hold_q until we learn whether it ends the line.
   always_comb begin
      state_d    = state_q;
      half_d     = half_q;
      half_vld_d = half_vld_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      sof_pend_d = sof_pend_q;
      fcnt_d     = fcnt_q;
      ovf_d      = ovf_q;
      push       = 1'b0;
      push_ent   = '0;
      if (vs_rise) begin
         state_d    = VS_HIGH;
         fcnt_d     = fcnt_q + FCNT_W'(1);
         ovf_d      = 1'b0;
         half_vld_d = 1'b0;
         hold_vld_d = 1'b0;
         sof_pend_d = 1'b1;
      end else begin
         case (state_q)
            VS_HIGH: if (!cmos_frame_vsync) state_d = ACTIVE;
            ACTIVE: begin
               if (pix) begin
                  if (hold_vld_q) begin
                     push       = 1'b1;
                     push_ent   = '{sof: sof_pend_q, eol: 1'b0, data: hold_q};
                     hold_vld_d = 1'b0;
                  end
                  if (half_vld_q) begin
                     hold_d     = {half_q, cmos_frame_data};
                     hold_vld_d = 1'b1;
                     half_vld_d = 1'b0;
                  end else begin
                     half_d     = cmos_frame_data;
                     half_vld_d = 1'b1;
                  end
               end else if (href_fall) begin
                  if (hold_vld_q) begin
                     push     = 1'b1;
                     push_ent = '{sof: sof_pend_q, eol: 1'b1, data: hold_q};
                  end else if (half_vld_q) begin
                     push     = 1'b1;
                     push_ent = '{sof: sof_pend_q, eol: 1'b1, data: {half_q, {PIX_W{1'b0}}}};
                  end
                  hold_vld_d = 1'b0;
                  half_vld_d = 1'b0;
               end
               if (push) begin
                  if (full && !pop) begin
                     ovf_d      = 1'b1;
                     state_d    = DROP;
                     half_vld_d = 1'b0;
                     hold_vld_d = 1'b0;
                  end else begin
                     sof_pend_d = 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= WAIT_VS;
         vs_q       <= 1'b0;
         href_q     <= 1'b0;
         half_q     <= '0;
         half_vld_q <= 1'b0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         sof_pend_q <= 1'b0;
         fcnt_q     <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         vs_q       <= cmos_frame_vsync;
         href_q     <= cmos_frame_href;
         half_q     <= half_d;
         half_vld_q <= half_vld_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         sof_pend_q <= sof_pend_d;
         fcnt_q     <= fcnt_d;
         ovf_q      <= ovf_d;
      end
   end

`ifdef CMOS_LINE_CHECK_EN
   logic [12:0] lcnt_q, lcnt_d;
   logic        lerr_q, lerr_d;

   always_comb begin
      lcnt_d = lcnt_q;
      lerr_d = lerr_q;
      if (vs_rise) begin
         lcnt_d = '0;
         lerr_d = 1'b0;
      end else if (state_q == ACTIVE) begin
         if (pix) begin
            lcnt_d = lcnt_q + 13'd1;
         end else if (href_fall) begin
            if (lcnt_q != cmos_hpixel) lerr_d = 1'b1;
            lcnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lcnt_q <= '0;
         lerr_q <= 1'b0;
      end else begin
         lcnt_q <= lcnt_d;
         lerr_q <= lerr_d;
      end
   end

   assign line_err = lerr_q;
`else
   logic unused_hpixel;
   assign unused_hpixel = ^cmos_hpixel;
   assign line_err      = 1'b0;
`endif

   pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en_i  (push),
      .wr_ent_i (push_ent),
      .full_o   (full),
      .rd_en_i  (pop),
      .rd_ent_o (head_ent),
      .empty_o  (empty)
   );

   assign wr_data   = head_ent.data;
   assign wr_sof    = head_ent.sof;
   assign wr_eol    = head_ent.eol;
   assign frame_cnt = fcnt_q;
   assign overflow  = ovf_q;
endmodule
